// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [WORD_W-1:0] RSP_ZERO = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request fields held across the wait states
  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [WORD_W-1:0] wdata;
  } req_payload_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [BE_W-1:0]       be,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; read data only updates on an enabled load
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < int'(BE_W); b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, programmable wait states,
// then a held response carrying the read word or a write acknowledge.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  state_e                state_q, state_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  req_payload_t          pay_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  err_q;
  logic                  rd_ok_q;

  logic                  req_err_c;
  logic [ADDR_WIDTH-1:0] req_idx_c;
  logic                  enter_resp_c;
  logic                  op_we, op_err;
  logic [BE_W-1:0]       op_be;
  logic [ADDR_WIDTH-1:0] op_idx;
  logic [WORD_W-1:0]     op_wdata;
  logic                  mem_en_c;
  logic [WORD_W-1:0]     mem_rdata;

  assign req_err_c = ((req_addr >> (ADDR_WIDTH + 2)) != 32'h0) || (req_be == '0);
  assign req_idx_c = req_addr[ADDR_WIDTH+1:2];

  // Next-state logic; with zero latency the RAM operation uses the live request
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    op_we     = pay_q.we;
    op_be     = pay_q.be;
    op_wdata  = pay_q.wdata;
    op_idx    = idx_q;
    op_err    = err_q;
    case (state_q)
      IDLE: begin
        op_we    = req_we;
        op_be    = req_be;
        op_wdata = req_wdata;
        op_idx   = req_idx_c;
        op_err   = req_err_c;
        if (req_valid) begin
          cnt_nxt   = CNT_W'(LATENCY);
          state_nxt = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp_c = (state_q != RESP) && (state_nxt == RESP);
  assign mem_en_c     = enter_resp_c && !op_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pay_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      rd_ok_q   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      if (state_q == IDLE && req_valid) begin
        pay_q <= '{we: req_we, be: req_be, wdata: req_wdata};
        idx_q <= req_idx_c;
        err_q <= req_err_c;
      end
      if (enter_resp_c) begin
        rsp_err <= op_err;
        rd_ok_q <= !op_err && !op_we;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_err <= 1'b0;
        rd_ok_q <= 1'b0;
      end
    end
  end

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .en    (mem_en_c),
    .we    (op_we),
    .be    (op_be),
    .idx   (op_idx),
    .wdata (op_wdata),
    .rdata (mem_rdata)
  );

  // The RAM output register holds the load word; stores and errors read as zero
  assign rsp_rdata = rd_ok_q ? mem_rdata : RSP_ZERO;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance plus a LATENCY=0 instance.
module tb_dmem_responder;

  logic        clk;
  logic        rst;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  int vecs;
  int errs;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with rsp_ready high; edges counted from the edge before the request
  task automatic issue(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output int lat, output logic [31:0] rd, output logic er);
    logic rv;
    if (sel) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
    end
    lat = 0;
    rv  = 1'b0;
    while (!rv && lat < 40) begin
      step();
      lat++;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      rv = sel ? b_rsp_valid : a_rsp_valid;
    end
    rd = sel ? b_rsp_rdata : a_rsp_rdata;
    er = sel ? b_rsp_err : a_rsp_err;
    step();
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  logic [31:0] held;

  initial begin
    vecs = 0;
    errs = 0;
    rst = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;

    repeat (3) step();
    rst = 1'b1;
    step();
    check("rst_req_ready", 32'(a_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rsp_rdata", a_rsp_rdata, 32'h0);
    check("rst_rsp_err",   32'(a_rsp_err), 32'd0);

    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    check("st_latency", 32'(lat), 32'd3);
    check("st_rdata",   rd, 32'h0);
    check("st_err",     32'(er), 32'd0);
    check("st_post_valid", 32'(a_rsp_valid), 32'd0);
    check("st_post_ready", 32'(a_req_ready), 32'd1);

    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    check("ld_latency", 32'(lat), 32'd3);
    check("ld_rdata",   rd, 32'hDEADBEEF);
    check("ld_err",     32'(er), 32'd0);
    check("ld_post_rdata", a_rsp_rdata, 32'h0);

    issue(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0100, lat, rd, er);
    check("be_st_err", 32'(er), 32'd0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    check("be_ld_rdata", rd, 32'hDE22BEEF);

    issue(1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, lat, rd, er);
    check("oor_err",   32'(er), 32'd1);
    check("oor_rdata", rd, 32'h0);
    check("oor_post_err", 32'(a_rsp_err), 32'd0);

    issue(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, lat, rd, er);
    check("be0_err",   32'(er), 32'd1);
    check("be0_rdata", rd, 32'h0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    check("be0_unchanged", rd, 32'hDE22BEEF);

    // Backpressure: stall in RESP while a competing store is presented
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h10; a_req_be = 4'hF;
    step();
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd3);
    held = a_rsp_rdata;
    check("bp_rdata", held, 32'hDE22BEEF);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10; a_req_wdata = 32'h0; a_req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid_hold", 32'(a_rsp_valid), 32'd1);
      check("bp_rdata_hold", a_rsp_rdata, held);
      check("bp_req_ready",  32'(a_req_ready), 32'd0);
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(a_rsp_valid), 32'd0);
    check("bp_release_ready", 32'(a_req_ready), 32'd1);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    check("bp_store_ignored", rd, 32'hDE22BEEF);

    // Reset during the wait states of a store
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10; a_req_wdata = 32'h0; a_req_be = 4'hF;
    step();
    a_req_valid = 1'b0;
    check("mid_in_wait", 32'(a_req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(a_req_ready), 32'd1);
    check("mid_rst_valid", 32'(a_rsp_valid), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    step();
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    check("mid_old_data", rd, 32'hDE22BEEF);

    // Zero-latency instance
    issue(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, lat, rd, er);
    check("l0_st_latency", 32'(lat), 32'd1);
    check("l0_st_rdata",   rd, 32'h0);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er);
    check("l0_ld_latency", 32'(lat), 32'd1);
    check("l0_ld_rdata",   rd, 32'hCAFEF00D);
    check("l0_post_ready", 32'(b_req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
